// File: rtl/icache_direct_if.sv
// Fetch-side and system-bus-side signal bundle for icache_direct.
//   slave  : the cache's view (takes fetch requests, masters the line-read bus)
//   master : the environment's view (fetch stage plus bus responder)
// Fetch side : ic_req, ic_line_addr[57:0], ic_word_select[3:0] -> ic_ack, ic_data_out[31:0]
// Bus side   : bus_reqcyc/bus_req/bus_reqtag -> bus_reqack;
//              bus_respcyc/bus_resp/bus_resptag -> bus_respack
interface icache_direct_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      ic_req;
  logic [57:0]               ic_line_addr;
  logic [3:0]                ic_word_select;
  logic                      ic_ack;
  logic [31:0]               ic_data_out;
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport slave (
    input  ic_req, ic_line_addr, ic_word_select,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output ic_ack, ic_data_out,
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

  modport master (
    output ic_req, ic_line_addr, ic_word_select,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  ic_ack, ic_data_out,
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache in front of the fetch stage.
// A hit answers one cycle after the request is sampled; a miss reads the
// whole 64-byte line as eight 64-bit bus beats, installs it, then answers.
// Ports:
//   clk   : clock, all state changes on posedge
//   reset : synchronous active-high reset
//   cif   : icache_direct_if.slave (fetch request/ack and bus read channel)
module icache_direct #(
  parameter int                      BUS_DATA_WIDTH = 64,
  parameter int                      BUS_TAG_WIDTH  = 13,
  parameter int                      SETS           = 64,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG      = 13'h1100
) (
  input logic           clk,
  input logic           reset,
  icache_direct_if.slave cif
);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 58 - IDX;

  typedef enum logic [2:0] {IDLE, HIT, MISSREQ, FILL, RESP} state_t;

  state_t           state;
  state_t           next_state;
  logic [SETS-1:0]  valid;
  logic [TAGW-1:0]  tag_mem  [SETS];
  logic [31:0]      data_mem [SETS][16];
  logic [57:0]      lat_line;
  logic [3:0]       lat_ws;
  logic [2:0]       beat_cnt;
  logic [31:0]      out_word;

  logic [IDX-1:0]   req_idx;
  logic [TAGW-1:0]  req_tag;
  logic [IDX-1:0]   lat_idx;
  logic [TAGW-1:0]  lat_tag;
  logic             lookup_hit;
  logic             beat_take;
  logic             last_beat;
  logic             unused_resptag;

  assign req_idx    = cif.ic_line_addr[IDX-1:0];
  assign req_tag    = cif.ic_line_addr[57:IDX];
  assign lat_idx    = lat_line[IDX-1:0];
  assign lat_tag    = lat_line[57:IDX];
  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign beat_take  = (state == FILL) && cif.bus_respcyc;
  assign last_beat  = beat_take && (beat_cnt == 3'd7);

  // Response tags carry no meaning for a single-outstanding read.
  assign unused_resptag = ^cif.bus_resptag;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cif.ic_req) next_state = lookup_hit ? HIT : MISSREQ;
      HIT:     next_state = IDLE;
      MISSREQ: if (cif.bus_reqack) next_state = FILL;
      FILL:    if (last_beat) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decode straight from state. Beats are always accepted, even
  // outside FILL, so a responder left mid-line by a reset can drain.
  always_comb begin
    cif.ic_ack      = (state == HIT) || (state == RESP);
    cif.ic_data_out = cif.ic_ack ? out_word : 32'd0;
    cif.bus_reqcyc  = (state == MISSREQ);
    cif.bus_req     = cif.bus_reqcyc ? {lat_line, 6'b000000} : '0;
    cif.bus_reqtag  = cif.bus_reqcyc ? READ_TAG : '0;
    cif.bus_respack = cif.bus_respcyc;
  end

  // out_word is loaded from the array on a lookup, and on a miss is
  // overwritten by the requested word as its beat streams past, so RESP
  // needs no extra array read.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= '0;
      lat_line <= '0;
      lat_ws   <= '0;
      beat_cnt <= '0;
      out_word <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cif.ic_req) begin
            lat_line <= cif.ic_line_addr;
            lat_ws   <= cif.ic_word_select;
            out_word <= data_mem[req_idx][cif.ic_word_select];
          end
        end
        MISSREQ: begin
          if (cif.bus_reqack) begin
            beat_cnt       <= '0;
            valid[lat_idx] <= 1'b0;
          end
        end
        FILL: begin
          if (beat_take) begin
            beat_cnt <= beat_cnt + 3'd1;
            if (lat_ws[3:1] == beat_cnt)
              out_word <= lat_ws[0] ? cif.bus_resp[63:32] : cif.bus_resp[31:0];
            if (beat_cnt == 3'd7) valid[lat_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays are not reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (!reset && beat_take) begin
      data_mem[lat_idx][{beat_cnt, 1'b0}] <= cif.bus_resp[31:0];
      data_mem[lat_idx][{beat_cnt, 1'b1}] <= cif.bus_resp[63:32];
    end
    if (!reset && last_beat) tag_mem[lat_idx] <= lat_tag;
  end
endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus a random
// access mix, checked against a set/tag model of a direct-mapped cache and
// a synthetic backing memory.
module tb_icache_direct;
  localparam int SETS = 64;
  localparam int IDX  = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icache_direct_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) cif ();

  icache_direct #(
    .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .SETS(SETS), .READ_TAG(13'h1100)
  ) dut (
    .clk(clk), .reset(reset), .cif(cif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which line each set holds, if any.
  bit          model_valid [SETS];
  logic [57:0] model_line  [SETS];

  function automatic bit model_hit(logic [57:0] line);
    int idx = int'(line % SETS);
    return model_valid[idx] && (model_line[idx] == line);
  endfunction

  function automatic void model_fill(logic [57:0] line);
    int idx = int'(line % SETS);
    model_valid[idx] = 1'b1;
    model_line[idx]  = line;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < SETS; i++) model_valid[i] = 1'b0;
  endfunction

  // Backing memory: line 0x40 holds word index as data, others a pattern.
  function automatic logic [31:0] mem_word(logic [57:0] line, int w);
    logic [3:0] w4 = 4'(w);
    if (line == 58'h40) return 32'(w);
    return {line[23:0], 4'h5, w4};
  endfunction

  // Observations from one access.
  int          obs_acks, obs_ack_cyc, obs_nreq, obs_respacks, obs_last_beat_cyc, obs_respack_bad;
  logic [63:0] obs_req_addr;
  logic [31:0] obs_data;
  bit          obs_req_const, obs_tag_ok, obs_double;

  // Drives one fetch request and plays the bus responder until the ack
  // (or, when reset_after_beat >= 0, resets mid-fill and drains the line).
  task automatic apply_stimulus(input logic [57:0] line, input logic [3:0] ws,
                                input int reqack_dly, input int gap,
                                input int reset_after_beat, input logic [57:0] alt_line);
    int cyc = 0, wait_cnt = 0, beats = 0, gap_cnt = gap, phase = 0, ack_at = -1;
    bit prev_ack = 0, prev_reqcyc = 0, did_reset = 0;
    obs_acks = 0; obs_ack_cyc = -1; obs_nreq = 0; obs_respacks = 0; obs_last_beat_cyc = -1;
    obs_respack_bad = 0; obs_req_addr = '0; obs_data = '0;
    obs_req_const = 1; obs_tag_ok = 1; obs_double = 0;
    @(negedge clk);
    cif.ic_req = 1'b1; cif.ic_line_addr = line; cif.ic_word_select = ws;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        checks++; errors++;
        $display("[TB] FAIL access_timeout: line %0h got no completion in 400 cycles", line);
        break;
      end
      if (cif.ic_ack) begin
        if (prev_ack) obs_double = 1;
        obs_acks++;
        if (ack_at < 0) begin
          ack_at = cyc; obs_ack_cyc = cyc; obs_data = cif.ic_data_out;
          cif.ic_req = 1'b0;
        end
      end
      prev_ack = cif.ic_ack;
      if (cif.bus_reqcyc) begin
        if (!prev_reqcyc) begin obs_nreq++; obs_req_addr = cif.bus_req; end
        else if (cif.bus_req !== obs_req_addr) obs_req_const = 0;
        if (cif.bus_reqtag !== 13'h1100) obs_tag_ok = 0;
      end
      prev_reqcyc = cif.bus_reqcyc;
      if (ack_at >= 0 && cyc > ack_at) break;
      if (did_reset && phase == 2) break;
      cif.bus_reqack = 1'b0; cif.bus_respcyc = 1'b0; reset = 1'b0;
      if (phase == 0 && cif.bus_reqcyc && !did_reset) begin
        if (alt_line != line) cif.ic_line_addr = alt_line;
        if (wait_cnt >= reqack_dly) begin cif.bus_reqack = 1'b1; phase = 1; end
        else wait_cnt++;
      end else if (phase == 1) begin
        if (reset_after_beat >= 0 && !did_reset && beats == reset_after_beat + 1) begin
          reset = 1'b1; cif.ic_req = 1'b0; did_reset = 1;
          continue;
        end
        if (gap_cnt >= gap) begin
          cif.bus_respcyc = 1'b1;
          cif.bus_resp    = {mem_word(line, 2*beats+1), mem_word(line, 2*beats)};
          cif.bus_resptag = 13'($urandom);
          gap_cnt = 0; beats++; obs_last_beat_cyc = cyc;
          if (beats == 8) phase = 2;
        end else gap_cnt++;
      end
      #1;
      if (cif.bus_respack !== cif.bus_respcyc) obs_respack_bad++;
      if (cif.bus_respcyc && cif.bus_respack) obs_respacks++;
    end
    cif.ic_req = 1'b0; cif.bus_reqack = 1'b0; cif.bus_respcyc = 1'b0; reset = 1'b0;
    cif.ic_line_addr = line;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks += 6;
    if (cif.ic_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ic_ack: got %b want 0", cif.ic_ack); end
    if (cif.ic_data_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", cif.ic_data_out); end
    if (cif.bus_reqcyc !== 1'b0) begin errors++; $display("[TB] FAIL reset_reqcyc: got %b want 0", cif.bus_reqcyc); end
    if (cif.bus_req !== 64'd0) begin errors++; $display("[TB] FAIL reset_req: got %h want 0", cif.bus_req); end
    if (cif.bus_reqtag !== 13'd0) begin errors++; $display("[TB] FAIL reset_reqtag: got %h want 0", cif.bus_reqtag); end
    if (cif.bus_respack !== 1'b0) begin errors++; $display("[TB] FAIL reset_respack: got %b want 0", cif.bus_respack); end
    reset = 1'b0;
    model_clear();
    // A stray beat in IDLE must still be accepted.
    @(negedge clk);
    cif.bus_respcyc = 1'b1; cif.bus_resp = 64'hDEAD_BEEF_0BAD_F00D;
    #1;
    checks++;
    if (cif.bus_respack !== 1'b1) begin errors++; $display("[TB] FAIL idle_respack: got %b want 1", cif.bus_respack); end
    @(negedge clk);
    cif.bus_respcyc = 1'b0;
    checks++;
    if (cif.ic_ack !== 1'b0) begin errors++; $display("[TB] FAIL idle_stray_ack: got %b want 0", cif.ic_ack); end
  endtask

  task automatic test_cold_miss();
    apply_stimulus(58'h40, 4'd3, 0, 0, -1, 58'h40);
    checks += 7;
    if (obs_nreq != 1) begin errors++; $display("[TB] FAIL cold_nreq: got %0d want 1", obs_nreq); end
    if (obs_req_addr !== 64'h1000) begin errors++; $display("[TB] FAIL cold_req_addr: got %h want 1000", obs_req_addr); end
    if (!obs_tag_ok) begin errors++; $display("[TB] FAIL cold_reqtag: got wrong tag want 1100"); end
    if (obs_respacks != 8 || obs_respack_bad != 0) begin errors++; $display("[TB] FAIL cold_respacks: got %0d (bad %0d) want 8", obs_respacks, obs_respack_bad); end
    if (obs_acks != 1 || obs_double) begin errors++; $display("[TB] FAIL cold_acks: got %0d want 1", obs_acks); end
    if (obs_ack_cyc != obs_last_beat_cyc + 1) begin errors++; $display("[TB] FAIL cold_latency: got cycle %0d want %0d", obs_ack_cyc, obs_last_beat_cyc + 1); end
    if (obs_data !== 32'd3) begin errors++; $display("[TB] FAIL cold_data: got %h want 3", obs_data); end
    model_fill(58'h40);
  endtask

  task automatic test_hit();
    apply_stimulus(58'h40, 4'd14, 0, 0, -1, 58'h40);
    checks += 4;
    if (obs_nreq != 0) begin errors++; $display("[TB] FAIL hit_nreq: got %0d want 0", obs_nreq); end
    if (obs_ack_cyc != 1) begin errors++; $display("[TB] FAIL hit_latency: got %0d want 1", obs_ack_cyc); end
    if (obs_data !== 32'd14) begin errors++; $display("[TB] FAIL hit_data: got %h want e", obs_data); end
    if (obs_acks != 1 || obs_double) begin errors++; $display("[TB] FAIL hit_acks: got %0d want 1", obs_acks); end
  endtask

  task automatic test_conflict();
    logic [57:0] other = 58'h40 + 58'(SETS);
    apply_stimulus(other, 4'd5, 0, 0, -1, other);
    checks += 3;
    if (obs_nreq != 1) begin errors++; $display("[TB] FAIL conflict_nreq: got %0d want 1", obs_nreq); end
    if (obs_req_addr !== {other, 6'b0}) begin errors++; $display("[TB] FAIL conflict_addr: got %h want %h", obs_req_addr, {other, 6'b0}); end
    if (obs_data !== mem_word(other, 5)) begin errors++; $display("[TB] FAIL conflict_data: got %h want %h", obs_data, mem_word(other, 5)); end
    model_fill(other);
    apply_stimulus(58'h40, 4'd7, 0, 0, -1, 58'h40);
    checks += 2;
    if (obs_nreq != (model_hit(58'h40) ? 0 : 1)) begin errors++; $display("[TB] FAIL conflict_rerequest_nreq: got %0d want 1", obs_nreq); end
    if (obs_data !== 32'd7) begin errors++; $display("[TB] FAIL conflict_rerequest_data: got %h want 7", obs_data); end
    model_fill(58'h40);
  endtask

  task automatic test_delayed();
    logic [57:0] line = 58'h123_4567;
    apply_stimulus(line, 4'd9, 5, 3, -1, line ^ 58'h3F0);
    checks += 6;
    if (obs_nreq != 1) begin errors++; $display("[TB] FAIL delayed_nreq: got %0d want 1", obs_nreq); end
    if (!obs_req_const || obs_req_addr !== {line, 6'b0}) begin errors++; $display("[TB] FAIL delayed_req_hold: got %h want %h constant", obs_req_addr, {line, 6'b0}); end
    if (obs_respacks != 8) begin errors++; $display("[TB] FAIL delayed_respacks: got %0d want 8", obs_respacks); end
    if (obs_acks != 1 || obs_double) begin errors++; $display("[TB] FAIL delayed_acks: got %0d want 1", obs_acks); end
    if (obs_ack_cyc != obs_last_beat_cyc + 1) begin errors++; $display("[TB] FAIL delayed_latency: got %0d want %0d", obs_ack_cyc, obs_last_beat_cyc + 1); end
    if (obs_data !== mem_word(line, 9)) begin errors++; $display("[TB] FAIL delayed_data: got %h want %h", obs_data, mem_word(line, 9)); end
    model_fill(line);
  endtask

  task automatic test_reset_mid_fill();
    logic [57:0] line = 58'h2A5;
    apply_stimulus(line, 4'd12, 0, 1, 4, line);
    checks += 3;
    if (obs_nreq != 1) begin errors++; $display("[TB] FAIL midreset_nreq: got %0d want 1", obs_nreq); end
    if (obs_acks != 0) begin errors++; $display("[TB] FAIL midreset_acks: got %0d want 0", obs_acks); end
    if (obs_respacks != 8) begin errors++; $display("[TB] FAIL midreset_respacks: got %0d want 8", obs_respacks); end
    model_clear();
    apply_stimulus(line, 4'd12, 0, 0, -1, line);
    checks += 2;
    if (obs_nreq != 1) begin errors++; $display("[TB] FAIL midreset_refetch_nreq: got %0d want 1", obs_nreq); end
    if (obs_data !== mem_word(line, 12)) begin errors++; $display("[TB] FAIL midreset_refetch_data: got %h want %h", obs_data, mem_word(line, 12)); end
    model_fill(line);
    // Reset also emptied 0x40; it must miss now.
    apply_stimulus(58'h40, 4'd1, 0, 0, -1, 58'h40);
    checks++;
    if (obs_nreq != 1) begin errors++; $display("[TB] FAIL midreset_other_nreq: got %0d want 1", obs_nreq); end
    model_fill(58'h40);
  endtask

  task automatic test_back_to_back();
    logic [57:0] line = 58'h155;
    logic [3:0]  ws;
    int acks = 0, last_ack = -10, cyc = 0, reqcycs = 0;
    bit prev = 0;
    apply_stimulus(line, 4'd0, 0, 0, -1, line);
    checks++;
    if (obs_acks != 1) begin errors++; $display("[TB] FAIL b2b_fill_acks: got %0d want 1", obs_acks); end
    model_fill(line);
    ws = 4'($urandom);
    @(negedge clk);
    cif.ic_req = 1'b1; cif.ic_line_addr = line; cif.ic_word_select = ws;
    while (acks < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cif.bus_reqcyc) reqcycs++;
      if (cif.ic_ack) begin
        checks += 3;
        if (prev) begin errors++; $display("[TB] FAIL b2b_consecutive_ack: got ack at %0d and %0d", cyc - 1, cyc); end
        if (cyc - last_ack != (acks == 0 ? cyc + 10 : 2)) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d want 2", cyc - last_ack); end
        if (cif.ic_data_out !== mem_word(line, int'(ws))) begin errors++; $display("[TB] FAIL b2b_data: got %h want %h", cif.ic_data_out, mem_word(line, int'(ws))); end
        acks++; last_ack = cyc;
        ws = 4'($urandom); cif.ic_word_select = ws;
      end
      prev = cif.ic_ack;
    end
    cif.ic_req = 1'b0;
    checks += 2;
    if (acks != 4) begin errors++; $display("[TB] FAIL b2b_ack_count: got %0d want 4", acks); end
    if (reqcycs != 0) begin errors++; $display("[TB] FAIL b2b_reqcyc: got %0d cycles want 0", reqcycs); end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [57:0] line = (58'($urandom_range(0, 3)) << IDX) | 58'($urandom_range(0, 3));
      logic [3:0]  ws   = 4'($urandom);
      bit          hit  = model_hit(line);
      apply_stimulus(line, ws, $urandom_range(0, 3), $urandom_range(0, 2), -1, line);
      checks += 4;
      if (obs_nreq != (hit ? 0 : 1)) begin errors++; $display("[TB] FAIL rand_nreq: line %h got %0d want %0d", line, obs_nreq, hit ? 0 : 1); end
      if (obs_data !== mem_word(line, int'(ws))) begin errors++; $display("[TB] FAIL rand_data: line %h ws %0d got %h want %h", line, ws, obs_data, mem_word(line, int'(ws))); end
      if (obs_acks != 1 || obs_double) begin errors++; $display("[TB] FAIL rand_acks: got %0d want 1", obs_acks); end
      if (obs_ack_cyc != (hit ? 1 : obs_last_beat_cyc + 1)) begin errors++; $display("[TB] FAIL rand_latency: got %0d want %0d", obs_ack_cyc, hit ? 1 : obs_last_beat_cyc + 1); end
      model_fill(line);
    end
  endtask

  initial begin
    reset = 1'b1;
    cif.ic_req = 1'b0; cif.ic_line_addr = '0; cif.ic_word_select = '0;
    cif.bus_reqack = 1'b0; cif.bus_respcyc = 1'b0; cif.bus_resp = '0; cif.bus_resptag = '0;
    model_clear();
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_delayed();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
